// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART register block with an RX byte FIFO, a single
// TX holding register, and free-running cycle / retired-instruction counters.
// Read data is registered so it lines up with synchronous BIOS/DMEM reads.
module uart_mmio #(
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] uart_out,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  input  logic        inst_retired
);

  localparam int unsigned PW       = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(RX_DEPTH);

  typedef enum logic [7:0] {
    OFF_STATUS = 8'h00,
    OFF_RXDATA = 8'h04,
    OFF_TXDATA = 8'h08,
    OFF_CYCLE  = 8'h10,
    OFF_INSTR  = 8'h14,
    OFF_CNTRST = 8'h18
  } reg_off_e;

  logic [7:0]    r_mem [RX_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic [7:0]    r_tx_data;
  logic          r_tx_full;
  logic [31:0]   r_cyc;
  logic [31:0]   r_inst;
  logic [31:0]   r_rdata;

  logic        w_sel;
  logic [7:0]  w_off;
  logic        w_rd;
  logic        w_wr;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_tx_hs;
  logic        w_tx_load;
  logic        w_cnt_clr;
  logic [31:0] w_rdata;

  assign w_sel     = (addr[31:28] == 4'b1000);
  assign w_off     = addr[7:0];
  assign w_rd      = rd_en & w_sel;
  assign w_wr      = wr_en & w_sel;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_push    = rx_valid_in & ~w_full;
  assign w_pop     = w_rd & (w_off == OFF_RXDATA) & ~w_empty;
  assign w_tx_hs   = r_tx_full & tx_ready_in;
  // Load is gated on the pre-edge full flag, so a write racing the emptying
  // handshake is dropped rather than refilling the register.
  assign w_tx_load = w_wr & (w_off == OFF_TXDATA) & ~r_tx_full;
  assign w_cnt_clr = w_wr & (w_off == OFF_CNTRST);

  assign rx_ready_out = ~w_full;
  assign tx_valid_out = r_tx_full;
  assign tx_data_out  = r_tx_data;
  assign uart_out     = r_rdata;

  // Read-data mux over current (pre-edge) state.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_STATUS: w_rdata = {30'b0, ~w_empty, ~r_tx_full};
      OFF_RXDATA: w_rdata = w_empty ? '0 : {24'b0, r_mem[r_rd_ptr]};
      OFF_CYCLE:  w_rdata = r_cyc;
      OFF_INSTR:  w_rdata = r_inst;
      default:    w_rdata = '0;
    endcase
  end

  // Registered read data; only selected reads update it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdata;
  end

  // RX FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data_in;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // TX holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_full <= 1'b0;
      r_tx_data <= '0;
    end else if (w_tx_load) begin
      r_tx_full <= 1'b1;
      r_tx_data <= wdata[7:0];
    end else if (w_tx_hs) begin
      r_tx_full <= 1'b0;
    end
  end

  // Cycle and retired-instruction counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc  <= '0;
      r_inst <= '0;
    end else if (w_cnt_clr) begin
      r_cyc  <= '0;
      r_inst <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (inst_retired) r_inst <= r_inst + 32'd1;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed stimulus with a read-data scoreboard; a monitor
// compares uart_out one cycle after every selected read.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] uart_out;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic        inst_retired;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  uart_mmio #(.RX_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .uart_out(uart_out), .rx_data_in(rx_data_in),
    .rx_valid_in(rx_valid_in), .rx_ready_out(rx_ready_out),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
    .tx_ready_in(tx_ready_in), .inst_retired(inst_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Advance one cycle (inputs are driven at posedge+1) and drop pulse inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    rx_valid_in = 1'b0;
    tx_ready_in = 1'b0;
  endtask

  task automatic rd_req(input logic [7:0] off, input logic [31:0] exp, input string nm);
    addr  = {4'h8, 20'h0, off};
    rd_en = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
  endtask

  task automatic wr_req(input logic [7:0] off, input logic [31:0] d);
    addr  = {4'h8, 20'h0, off};
    wr_en = 1'b1;
    wdata = d;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_valid_in = 1'b1;
    rx_data_in  = b;
  endtask

  // Monitor: a selected read at an edge is checked at the following negedge.
  initial begin
    logic fire;
    logic [31:0] e;
    string nm;
    forever begin
      @(posedge clk);
      fire = rd_en && (addr[31:28] == 4'h8) && rst_n;
      @(negedge clk);
      if (fire) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_read: got 0x%08h expected no read", uart_out);
        end else begin
          e  = exp_q.pop_front();
          nm = nm_q.pop_front();
          check(nm, uart_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    rx_data_in = '0; rx_valid_in = 1'b0; tx_ready_in = 1'b0; inst_retired = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_uart_out", uart_out, 32'h0);
    check("rst_rx_ready", {31'b0, rx_ready_out}, 32'h1);
    check("rst_tx_valid", {31'b0, tx_valid_out}, 32'h0);
    check("rst_tx_data",  {24'b0, tx_data_out},  32'h0);

    rd_req(8'h00, 32'h1, "status_reset"); tick();
    // Unselected access must leave uart_out alone.
    addr = 32'h0000_0004; rd_en = 1'b1; tick();
    check("unsel_hold", uart_out, 32'h1);

    push_rx(8'h41); tick();
    push_rx(8'h42); tick();
    rd_req(8'h00, 32'h3,  "status_rx");  tick();
    rd_req(8'h04, 32'h41, "rx_pop0");    tick();
    rd_req(8'h04, 32'h42, "rx_pop1");    tick();
    rd_req(8'h04, 32'h0,  "rx_empty");   tick();
    rd_req(8'h00, 32'h1,  "status_emp"); tick();

    // Push and pop together on an empty FIFO.
    rd_req(8'h04, 32'h0, "empty_pushpop"); push_rx(8'h77); tick();
    rd_req(8'h04, 32'h77, "empty_pushpop_byte"); tick();

    // Fill across the pointer wrap.
    for (int i = 0; i < 8; i++) begin
      push_rx(8'h10 + 8'(i)); tick();
    end
    check("full_ready", {31'b0, rx_ready_out}, 32'h0);
    push_rx(8'h99); tick();
    rd_req(8'h00, 32'h3, "status_full"); tick();
    rd_req(8'h04, 32'h10, "full_pop"); tick();
    check("ready_after_pop", {31'b0, rx_ready_out}, 32'h1);
    rd_req(8'h04, 32'h11, "pushpop7"); push_rx(8'hA0); tick();
    check("occ7_ready", {31'b0, rx_ready_out}, 32'h1);
    push_rx(8'hA1); tick();
    check("refull_ready", {31'b0, rx_ready_out}, 32'h0);
    for (int i = 2; i < 8; i++) begin
      rd_req(8'h04, 32'h10 + 32'(i), "drain"); tick();
    end
    rd_req(8'h04, 32'hA0, "drain_a0"); tick();
    rd_req(8'h04, 32'hA1, "drain_a1"); tick();
    rd_req(8'h04, 32'h0,  "drain_empty"); tick();
    check("drained_ready", {31'b0, rx_ready_out}, 32'h1);

    // TX holding register.
    wr_req(8'h08, 32'h55); tick();
    check("tx_valid_load", {31'b0, tx_valid_out}, 32'h1);
    check("tx_data_load",  {24'b0, tx_data_out},  32'h55);
    rd_req(8'h00, 32'h0, "status_txfull"); tick();
    wr_req(8'h08, 32'h66); tick();
    check("tx_drop_full", {24'b0, tx_data_out}, 32'h55);
    tx_ready_in = 1'b1; tick();
    check("tx_hs_clear", {31'b0, tx_valid_out}, 32'h0);
    rd_req(8'h00, 32'h1, "status_txempty"); tick();
    wr_req(8'h08, 32'h5A); tick();
    wr_req(8'h08, 32'h33); tx_ready_in = 1'b1; tick();
    check("tx_race_drop_valid", {31'b0, tx_valid_out}, 32'h0);
    check("tx_race_drop_data",  {24'b0, tx_data_out},  32'h5A);
    addr = 32'h0000_0008; wr_en = 1'b1; wdata = 32'h44; tick();
    check("tx_unsel_write", {31'b0, tx_valid_out}, 32'h0);

    rd_req(8'h0C, 32'h0, "unmapped_0c"); tick();
    rd_req(8'h00, 32'h1, "status_again"); tick();
    rd_req(8'h20, 32'h0, "unmapped_20"); tick();

    // Counters.
    wr_req(8'h18, 32'h0); tick();
    for (int i = 0; i < 100; i++) begin
      inst_retired = (i < 40); tick();
    end
    inst_retired = 1'b0;
    rd_req(8'h10, 32'd100, "cyc_100"); tick();
    rd_req(8'h14, 32'd40,  "inst_40"); tick();
    wr_req(8'h18, 32'h0); tick();
    rd_req(8'h10, 32'd0, "cyc_clr"); tick();
    rd_req(8'h14, 32'd0, "inst_clr"); tick();
    rd_req(8'h10, 32'd2, "cyc_after_clr"); tick();

    // Asynchronous reset mid-transfer.
    push_rx(8'h01); tick();
    push_rx(8'h02); tick();
    push_rx(8'h03); wr_req(8'h08, 32'h12); tick();
    rd_req(8'h00, 32'h2, "status_pre_rst"); tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_uart_out", uart_out, 32'h0);
    check("arst_rx_ready", {31'b0, rx_ready_out}, 32'h1);
    check("arst_tx_valid", {31'b0, tx_valid_out}, 32'h0);
    check("arst_tx_data",  {24'b0, tx_data_out},  32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_req(8'h00, 32'h1, "status_post_rst"); tick();
    rd_req(8'h04, 32'h0, "rx_post_rst"); tick();

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
